// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: CPU (m0) and debug/DMA loader (m1) share one dm port.
// Round-robin by default; define DM_ARB_FIXED_PRIO_EN to give m0 fixed priority.
module dm_port_arbiter #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [2:0]    m0_dmtype,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [2:0]    m1_dmtype,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_dmtype,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic          last_owner;
  logic          hold_we;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  logic [2:0]    hold_dmtype;

  logic accept;
  logic any_req;
  logic win;
  logic any_gnt;

  // Pick the winner and raise its grant at an accept point.
  always_comb begin
    accept  = !reset && (state != ACCESS);
    any_req = m0_req || m1_req;
`ifdef DM_ARB_FIXED_PRIO_EN
    win = m0_req ? 1'b0 : 1'b1;
`else
    if (m0_req && m1_req)
      win = ~last_owner;
    else
      win = m1_req;
`endif
    any_gnt = accept && any_req;
    m0_gnt  = any_gnt && !win;
    m1_gnt  = any_gnt && win;
  end

  // Memory side is driven straight from the holding registers;
  // only the write strobe is qualified by the ACCESS phase.
  always_comb begin
    mem_we     = (state == ACCESS) && hold_we && !reset;
    mem_addr   = hold_addr;
    mem_wdata  = hold_wdata;
    mem_dmtype = hold_dmtype;
    m0_rvalid  = (state == RESP) && !owner && !reset;
    m1_rvalid  = (state == RESP) && owner && !reset;
  end

  // Three-phase FSM: latch winner, access memory, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      owner       <= 1'b0;
      hold_we     <= 1'b0;
      hold_addr   <= '0;
      hold_wdata  <= '0;
      hold_dmtype <= '0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      case (state)
        ACCESS: begin
          if (!hold_we) begin
            if (owner)
              m1_rdata <= mem_rdata;
            else
              m0_rdata <= mem_rdata;
          end
          state <= RESP;
        end
        default: begin
          if (any_gnt) begin
            state       <= ACCESS;
            owner       <= win;
            last_owner  <= win;
            hold_we     <= win ? m1_we : m0_we;
            hold_addr   <= win ? m1_addr : m0_addr;
            hold_wdata  <= win ? m1_wdata : m0_wdata;
            hold_dmtype <= win ? m1_dmtype : m0_dmtype;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
